// File: rtl/pwm_duty_gen_pkg.sv
// Shared definitions for the PWM duty generator and the level counter feeding it.
package pwm_duty_gen_pkg;

  localparam int unsigned PWM_STEPS = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Saturate a requested level to the maximum legal level.
  function automatic int unsigned clamp_level(input int unsigned x, input int unsigned max_level);
    return (x > max_level) ? max_level : x;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Step-slot prescaler: counts 0..TICKS-1 and flags the last tick of each slot.
module pwm_prescaler #(
  parameter int unsigned TICKS = 100
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_wrap_c
);

  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_wrap_c = (r_cnt == LAST_TICK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_wrap_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_gen.sv
// Fixed-frequency PWM whose duty is level/STEPS, with the level latched only at period boundaries.
module pwm_duty_gen
  import pwm_duty_gen_pkg::*;
#(
  parameter int unsigned STEPS          = PWM_STEPS,
  parameter int unsigned TICKS_PER_STEP = 100,
  parameter int unsigned LEVEL_W        = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level,
  output logic               pwm_out,
  output logic               period_start,
  output logic [LEVEL_W-1:0] level_active
);

  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [STEP_W-1:0]  r_step_cnt;
  logic [STEP_W-1:0]  w_step_nxt;
  logic [LEVEL_W-1:0] r_level_active;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic [LEVEL_W-1:0] w_level_clamped;
  logic               r_pwm_out;
  logic               w_pwm_nxt;
  logic               r_period_start;
  logic               w_ps_nxt;
  logic               w_pre_clear;
  logic               w_pre_wrap;

  assign w_level_clamped = LEVEL_W'(clamp_level(32'(level), STEPS));

  pwm_prescaler #(
    .TICKS (TICKS_PER_STEP)
  ) u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clear  (w_pre_clear),
    .o_wrap_c (w_pre_wrap)
  );

  // Next-state, slot counting, level latch and output compare.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step_cnt;
    w_level_nxt = r_level_active;
    w_ps_nxt    = 1'b0;
    w_pwm_nxt   = 1'b0;
    w_pre_clear = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_step_nxt  = '0;
          w_level_nxt = w_level_clamped;
          w_ps_nxt    = 1'b1;
          w_pwm_nxt   = (w_level_clamped != '0);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = '0;
        end else begin
          w_pre_clear = 1'b0;
          if (w_pre_wrap) begin
            if (r_step_cnt == LAST_STEP) begin
              w_step_nxt  = '0;
              w_level_nxt = w_level_clamped;
              w_ps_nxt    = 1'b1;
            end else begin
              w_step_nxt = r_step_cnt + STEP_W'(1);
            end
          end
          w_pwm_nxt = (LEVEL_W'(w_step_nxt) < w_level_nxt);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_step_cnt     <= '0;
      r_level_active <= '0;
      r_pwm_out      <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_step_cnt     <= w_step_nxt;
      r_level_active <= w_level_nxt;
      r_pwm_out      <= w_pwm_nxt;
      r_period_start <= w_ps_nxt;
    end
  end

  assign pwm_out      = r_pwm_out;
  assign period_start = r_period_start;
  assign level_active = r_level_active;

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Scoreboard bench for pwm_duty_gen: a period-position model predicts every output cycle.
module tb_pwm_duty_gen;

  localparam int STEPS  = 10;
  localparam int TPS    = 4;
  localparam int PERIOD = STEPS * TPS;

  typedef struct packed {
    logic       pwm;
    logic       ps;
    logic [3:0] la;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [3:0] level;
  logic       pwm_out;
  logic       period_start;
  logic [3:0] level_active;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  pwm_duty_gen #(
    .STEPS          (STEPS),
    .TICKS_PER_STEP (TPS),
    .LEVEL_W        (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .level        (level),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .level_active (level_active)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  // Reference model: one position counter over the whole period.
  initial begin : model
    bit   run;
    int   pos;
    int   lvl;
    exp_t e;
    run = 0; pos = 0; lvl = 0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        run = 0; pos = 0; lvl = 0;
        exp_q.delete();
        exp_q.push_back('0);
      end else begin
        cyc++;
        if (!run) begin
          if (enable) begin
            run = 1; pos = 0;
            lvl = (int'(level) > STEPS) ? STEPS : int'(level);
          end
        end else if (!enable) begin
          run = 0; pos = 0;
        end else begin
          pos = (pos + 1) % PERIOD;
          if (pos == 0) lvl = (int'(level) > STEPS) ? STEPS : int'(level);
        end
        e.pwm = run && (pos < lvl * TPS);
        e.ps  = run && (pos == 0);
        e.la  = 4'(lvl);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: one expected entry per cycle, compared away from the active edge.
  initial begin : monitor
    exp_t e;
    @(posedge clock);
    forever begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("pwm_out", int'(pwm_out), int'(e.pwm));
        chk("period_start", int'(period_start), int'(e.ps));
        chk("level_active", int'(level_active), int'(e.la));
      end
    end
  end

  task automatic wait_ps();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
      @(negedge clock);
      if (period_start) seen = 1;
    end
    chk("period_start_timeout", int'(seen), 1);
  endtask

  initial begin : driver
    reset_n = 1'b0;
    enable  = 1'b0;
    level   = 4'd0;
    repeat (3) @(negedge clock);
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_ps", int'(period_start), 0);
    chk("reset_la", int'(level_active), 0);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clock);

    enable = 1'b1; level = 4'd3;
    repeat (3 * PERIOD) @(negedge clock);
    level = 4'd0;
    repeat (3 * PERIOD) @(negedge clock);
    level = 4'd10;
    repeat (3 * PERIOD) @(negedge clock);
    level = 4'd15;
    repeat (2 * PERIOD) @(negedge clock);

    // Mid-period level change takes effect only at the next boundary.
    level = 4'd2;
    wait_ps();
    wait_ps();
    repeat (5) @(negedge clock);
    level = 4'd7;
    repeat (2 * PERIOD) @(negedge clock);

    // Abort a period and restart it.
    level = 4'd5;
    wait_ps();
    wait_ps();
    repeat (6) @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    enable = 1'b1;
    repeat (PERIOD + 10) @(negedge clock);

    // Async reset during the high phase.
    wait_ps();
    repeat (8) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_ps", int'(period_start), 0);
    chk("async_rst_la", int'(level_active), 0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (PERIOD + 20) @(negedge clock);

    // Random levels and enable drops.
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 24) == 0) level = 4'($urandom_range(0, 15));
      if (enable && $urandom_range(0, 59) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
    end

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
